// File: rtl/uart_rx_deserializer_if.sv
// Signal bundle between the RX pin side and the receive frame engine.
// The master drives the serial line and parity config; the slave returns the byte and status.
interface uart_rx_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;
    logic                  busy;

    modport master (
        output rx_in, par_en, par_typ,
        input  data_out, data_valid, par_err, stop_err, busy
    );

    modport slave (
        input  rx_in, par_en, par_typ,
        output data_out, data_valid, par_err, stop_err, busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start-glitch rejection, 3-sample majority vote, LSB-first deserializer.
// Optional parity checking is built only when RX_PARITY_EN is defined.
module uart_rx_deserializer #(
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    uart_rx_deserializer_if.slave bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TickPre  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TickMid  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TickPost = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BitLast  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic                  vote_q, vote_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  serr_q, serr_d;
    logic                  vote;

`ifdef RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic mismatch_q, mismatch_d;
    logic perr_q, perr_d;
`else
    logic unused_par;
    assign unused_par = bus.par_en ^ bus.par_typ;
`endif

    // Third sample is the live synchronized line at tick M+1.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            vote_q    <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            serr_q    <= 1'b0;
`ifdef RX_PARITY_EN
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            mismatch_q <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            vote_q    <= vote_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            serr_q    <= serr_d;
`ifdef RX_PARITY_EN
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            mismatch_q <= mismatch_d;
            perr_q     <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        vote_d    = vote_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        serr_d    = 1'b0;
`ifdef RX_PARITY_EN
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        mismatch_d = mismatch_q;
        perr_d     = 1'b0;
`endif
        if (tick_q == TickPre)  samp_d[0] = rx_s_q;
        if (tick_q == TickMid)  samp_d[1] = rx_s_q;
        if (tick_q == TickPost) vote_d    = vote;

        unique case (state_q)
            StIdle: begin
                tick_d    = '0;
                bit_cnt_d = '0;
                // The cycle that sees the falling edge counts as tick 0.
                if (!rx_s_q) begin
                    state_d = StStart;
                    tick_d  = TW'(1);
                end
            end
            StStart: begin
                if (tick_q == TickLast) begin
                    if (!vote_q) begin
                        state_d = StData;
`ifdef RX_PARITY_EN
                        par_en_d   = bus.par_en;
                        par_typ_d  = bus.par_typ;
                        mismatch_d = 1'b0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick_q == TickLast) begin
                    shift_d   = {vote_q, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitLast) begin
`ifdef RX_PARITY_EN
                        state_d = par_en_q ? StParity : StStop;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef RX_PARITY_EN
                if (tick_q == TickLast) begin
                    mismatch_d = vote_q ^ (^shift_q) ^ par_typ_q;
                    state_d    = StStop;
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                // Decide mid-bit so a start edge right after the stop bit is not missed.
                if (tick_q == TickPost) begin
                    state_d = StIdle;
                    if (!vote) begin
                        serr_d = 1'b1;
`ifdef RX_PARITY_EN
                    end else if (mismatch_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.stop_err   = serr_q;
    assign bus.busy       = (state_q != StIdle);
`ifdef RX_PARITY_EN
    assign bus.par_err    = perr_q;
`else
    assign bus.par_err    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven on the line while a scoreboard
// holds the expected pulse kind, data and cycle; a negedge monitor pops and compares.
module tb_uart_rx_deserializer;
    localparam int unsigned OS = 8;
    localparam int unsigned DW = 8;
    localparam logic [2:0] KValid = 3'b001;
    localparam logic [2:0] KPar   = 3'b010;
    localparam logic [2:0] KStop  = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    exp_t       sb[$];
    int         n;

    uart_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line driven at a negedge with posedge count n: rx_s is low from count n+2 (cycle 0),
    // so the result pulse lands at n + 2 + F*OS + OS/2 + 2.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit use_par,
                              input logic par_bit);
        exp_t e;
        int   f;
        f = use_par ? 10 : 9;
        e.cyc = cyc + 2 + f * OS + OS / 2 + 2;
        if (!stop) e.kind = KStop;
        else if (use_par && (par_bit !== (bus.par_typ ^ (^d)))) e.kind = KPar;
        else e.kind = KValid;
        if (e.kind == KValid) model_data = d;
        e.data = model_data;
        sb.push_back(e);
        bus.rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = d[i];
            repeat (OS) @(negedge clk);
        end
        if (use_par) begin
            bus.rx_in = par_bit;
            repeat (OS) @(negedge clk);
        end
        bus.rx_in = stop;
        repeat (OS) @(negedge clk);
        bus.rx_in = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] kind;
        if (bus.data_valid || bus.par_err || bus.stop_err) begin
            kind = {bus.stop_err, bus.par_err, bus.data_valid};
            chk("pulse_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_kind", kind, e.kind);
                chk("pulse_data_out", bus.data_out, e.data);
                chk("pulse_cycle", cyc, e.cyc);
                chk("busy_at_pulse", bus.busy, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.rx_in   = 1'b1;
        bus.par_en  = 1'b0;
        bus.par_typ = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_par_err", bus.par_err, 0);
        chk("rst_stop_err", bus.stop_err, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Plain frame 0xA5.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("a5_data_out", bus.data_out, 8'hA5);
        chk("a5_busy_idle", bus.busy, 0);
        repeat (10) @(negedge clk);

        // Stop bit 0: line still low when FSM returns to idle, so a new frame starts.
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("stoperr_restart_busy", bus.busy, 1);
        repeat (20) @(negedge clk);
        chk("stoperr_busy_idle", bus.busy, 0);
        chk("stoperr_data_held", bus.data_out, 8'hA5);

        // 3-cycle start glitch.
        n = cyc;
        bus.rx_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx_in = 1'b1;
        @(negedge clk);
        chk("glitch_busy_high", bus.busy, 1);
        while (cyc < n + 12) @(negedge clk);
        chk("glitch_busy_low", bus.busy, 0);
        chk("glitch_data_held", bus.data_out, 8'hA5);
        repeat (10) @(negedge clk);

        // Back-to-back frames; expected cycles are exactly 80 apart.
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("b2b_data_out", bus.data_out, 8'h34);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 4 of a 0x7E frame.
        bus.rx_in = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = (8'h7E >> i) & 8'h01;
            repeat (OS) @(negedge clk);
        end
        bus.rx_in = 1'b1;
        repeat (OS / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_data_out", bus.data_out, 0);
        chk("midrst_valid", bus.data_valid, 0);
        chk("midrst_par_err", bus.par_err, 0);
        chk("midrst_stop_err", bus.stop_err, 0);
        chk("midrst_busy", bus.busy, 0);
        model_data = 8'h00;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("post_rst_data_out", bus.data_out, 8'h7E);
        repeat (10) @(negedge clk);

`ifdef RX_PARITY_EN
        bus.par_en  = 1'b1;
        bus.par_typ = 1'b0;
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_even_ok_data", bus.data_out, 8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("par_err_data_held", bus.data_out, 8'h03);
        bus.par_typ = 1'b1;
        send_frame(8'hC1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        chk("par_odd_ok_data", bus.data_out, 8'hC1);
        // Stop error wins over a parity mismatch.
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        repeat (30) @(negedge clk);
        bus.par_en = 1'b0;
`else
        // Parity inputs are ignored in this build.
        bus.par_en  = 1'b1;
        bus.par_typ = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("nopar_data_out", bus.data_out, 8'h03);
        bus.par_en = 1'b0;
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
